// File: rtl/iob_bus_arbiter_pkg.sv
// Shared definitions for the two-master IOb arbiter: FSM encoding and
// widths of the packed request/response bundles.
package iob_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_RD_WAIT = 2'd2
    } arb_state_e;

    // Request bundle layout: {avalid, addr, wdata, wstrb}
    function automatic int req_w(input int addr_w, input int data_w);
        return 1 + addr_w + data_w + data_w / 8;
    endfunction

    // Response bundle layout: {rvalid, rdata}
    function automatic int resp_w(input int data_w);
        return 1 + data_w;
    endfunction

endpackage

// File: rtl/iob_rr_arb2.sv
// Combinational two-way grant: a sole requester wins; a tie goes to the
// master that was not served last, or always to master 1 in fixed mode.
module iob_rr_arb2 #(
    parameter int FIXED_PRIO = 0
) (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       sel_o,
    output logic       any_o
);

    always_comb begin
        any_o = |req_i;
        if (req_i == 2'b11) begin
            sel_o = (FIXED_PRIO != 0) ? 1'b1 : ~last_i;
        end else begin
            sel_o = req_i[1];
        end
    end

endmodule

// File: rtl/iob_bus_arbiter.sv
// Shares one IOb native slave port between two masters, one transaction in
// flight; writes finish on s_ready_i, reads finish on s_rvalid_i.
module iob_bus_arbiter
    import iob_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cke_i,

    input  logic                m0_avalid_i,
    input  logic [ADDR_W-1:0]   m0_addr_i,
    input  logic [DATA_W-1:0]   m0_wdata_i,
    input  logic [DATA_W/8-1:0] m0_wstrb_i,
    output logic                m0_ready_o,
    output logic                m0_rvalid_o,
    output logic [DATA_W-1:0]   m0_rdata_o,

    input  logic                m1_avalid_i,
    input  logic [ADDR_W-1:0]   m1_addr_i,
    input  logic [DATA_W-1:0]   m1_wdata_i,
    input  logic [DATA_W/8-1:0] m1_wstrb_i,
    output logic                m1_ready_o,
    output logic                m1_rvalid_o,
    output logic [DATA_W-1:0]   m1_rdata_o,

    output logic                s_avalid_o,
    output logic [ADDR_W-1:0]   s_addr_o,
    output logic [DATA_W-1:0]   s_wdata_o,
    output logic [DATA_W/8-1:0] s_wstrb_o,
    input  logic                s_ready_i,
    input  logic                s_rvalid_i,
    input  logic [DATA_W-1:0]   s_rdata_i
);

    localparam int REQ_W  = req_w(ADDR_W, DATA_W);
    localparam int RESP_W = resp_w(DATA_W);

    arb_state_e state_q;
    logic       gnt_q;
    logic       last_q;

    logic              arb_sel;
    logic              arb_any;
    logic              drv_en;
    logic              drv_sel;
    logic              accept;
    logic              is_write;
    logic              rd_done;
    logic [REQ_W-1:0]  m0_req;
    logic [REQ_W-1:0]  m1_req;
    logic [REQ_W-1:0]  s_req;
    logic [RESP_W-1:0] m0_resp;
    logic [RESP_W-1:0] m1_resp;

    iob_rr_arb2 #(
        .FIXED_PRIO(FIXED_PRIO)
    ) u_arb (
        .req_i ({m1_avalid_i, m0_avalid_i}),
        .last_i(last_q),
        .sel_o (arb_sel),
        .any_o (arb_any)
    );

    assign m0_req = {m0_avalid_i, m0_addr_i, m0_wdata_i, m0_wstrb_i};
    assign m1_req = {m1_avalid_i, m1_addr_i, m1_wdata_i, m1_wstrb_i};

    // IDLE forwards the fresh arbitration result with zero latency; REQ
    // forwards only the granted master; RD_WAIT keeps the slave bus quiet.
    always_comb begin
        drv_en  = 1'b0;
        drv_sel = gnt_q;
        case (state_q)
            ST_IDLE: begin
                drv_en  = arb_any;
                drv_sel = arb_sel;
            end
            ST_REQ: begin
                drv_en = gnt_q ? m1_avalid_i : m0_avalid_i;
            end
            default: begin
                drv_en = 1'b0;
            end
        endcase
        s_req = '0;
        if (drv_en) begin
            s_req = drv_sel ? m1_req : m0_req;
        end
    end

    assign {s_avalid_o, s_addr_o, s_wdata_o, s_wstrb_o} = s_req;

    assign accept     = drv_en & s_ready_i;
    assign is_write   = |s_wstrb_o;
    assign m0_ready_o = accept & ~drv_sel;
    assign m1_ready_o = accept & drv_sel;

    // Stray s_rvalid_i outside RD_WAIT never reaches a master.
    assign rd_done = (state_q == ST_RD_WAIT) & s_rvalid_i;
    assign m0_resp = {rd_done & ~gnt_q, s_rdata_i};
    assign m1_resp = {rd_done & gnt_q, s_rdata_i};
    assign {m0_rvalid_o, m0_rdata_o} = m0_resp;
    assign {m1_rvalid_o, m1_rdata_o} = m1_resp;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
        end else if (cke_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (arb_any) begin
                        gnt_q <= arb_sel;
                        if (s_ready_i) begin
                            last_q  <= arb_sel;
                            state_q <= is_write ? ST_IDLE : ST_RD_WAIT;
                        end else begin
                            state_q <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    // A master withdrawing its request is dropped without a transfer.
                    if (!drv_en) begin
                        state_q <= ST_IDLE;
                    end else if (s_ready_i) begin
                        last_q  <= gnt_q;
                        state_q <= is_write ? ST_IDLE : ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (s_rvalid_i) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
